// File: rtl/mat_result_streamer.sv
// mat_result_streamer
// Output stage of the 2x2 int8 matrix multiplier. It takes one packed result
// frame, adds a saturating signed bias to each element, optionally applies
// ReLU, and streams the elements out one byte per transfer, first element
// first. It also counts the frames that have been fully emitted.
module mat_result_streamer #(
  parameter int DATA_W  = 8,
  parameter int N_ELEM  = 4,
  parameter int RELU_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_ELEM*DATA_W-1:0]   in_data,
  input  logic [DATA_W-1:0]          in_bias,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [1:0]                 out_idx,
  output logic                       out_last,
  output logic [CNT_W-1:0]           frame_cnt
);

  localparam logic [1:0] IDX_LAST = 2'(N_ELEM - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              idx_reg, idx_next;
  logic [CNT_W-1:0]        frame_cnt_reg, frame_cnt_next;
  logic                    load;
  logic                    last_beat;
  logic [DATA_W-1:0]       buf_reg [N_ELEM];
  logic [DATA_W-1:0]       proc    [N_ELEM];

  // Per-element bias add, saturation and ReLU, evaluated on the incoming
  // frame so the result can be captured in a single cycle at accept time.
  generate
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
      logic [DATA_W-1:0] elem;
      logic [DATA_W:0]   sum;
      logic [DATA_W-1:0] sat;

      // Element 0 sits in the top byte of the packed word.
      assign elem = in_data[(N_ELEM-1-gi)*DATA_W +: DATA_W];
      assign sum  = {elem[DATA_W-1], elem} + {in_bias[DATA_W-1], in_bias};

      // Clamp the one-bit-wider sum back into the signed element range.
      always_comb begin
        sat = sum[DATA_W-1:0];
        if (sum[DATA_W] != sum[DATA_W-1]) begin
          sat = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                            : {1'b0, {(DATA_W-1){1'b1}}};
        end
      end

      assign proc[gi] = ((RELU_EN != 0) && sat[DATA_W-1]) ? '0 : sat;

      // Frame buffer slot: cleared on reset, captured when a frame is accepted.
      always_ff @(posedge clk) begin
        if (reset) begin
          buf_reg[gi] <= '0;
        end else if (load) begin
          buf_reg[gi] <= proc[gi];
        end
      end
    end
  endgenerate

  assign last_beat = (idx_reg == IDX_LAST);

  // Next-state, handshake and output decode for the IDLE/SEND controller.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    frame_cnt_next = frame_cnt_reg;
    load           = 1'b0;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_data       = '0;
    out_idx        = '0;
    out_last       = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          idx_next   = '0;
          state_next = SEND;
        end
      end

      SEND: begin
        out_valid = 1'b1;
        out_data  = buf_reg[idx_reg];
        out_idx   = idx_reg;
        out_last  = last_beat;
        // A new frame may enter on the same edge that the last byte leaves,
        // which keeps back-to-back frames free of bubbles.
        in_ready  = out_ready && last_beat;
        if (out_ready) begin
          if (!last_beat) begin
            idx_next = idx_reg + 2'd1;
          end else begin
            frame_cnt_next = frame_cnt_reg + CNT_W'(1);
            idx_next       = '0;
            if (in_valid) begin
              load = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Controller state, element index and frame counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_mat_result_streamer.sv
// Scoreboard bench for mat_result_streamer. Two instances share all inputs:
// one with ReLU and a 16-bit counter, one without ReLU and a 2-bit counter
// so the counter wrap is observed. Stimulus pushes hand-computed bytes into
// per-instance queues; monitors pop and compare on every output transfer.
module tb_mat_result_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic [7:0]  in_bias;
  logic        out_ready;

  logic        in_ready1, out_valid1, out_last1;
  logic [7:0]  out_data1;
  logic [1:0]  out_idx1;
  logic [15:0] frame_cnt1;

  logic        in_ready0, out_valid0, out_last0;
  logic [7:0]  out_data0;
  logic [1:0]  out_idx0;
  logic [1:0]  frame_cnt0;

  typedef struct {
    logic [7:0] d;
    logic [1:0] i;
    logic       l;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   xfer_cyc[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   fc = 0;

  mat_result_streamer #(.DATA_W(8), .N_ELEM(4), .RELU_EN(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_bias(in_bias), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_idx(out_idx1),
    .out_last(out_last1), .frame_cnt(frame_cnt1)
  );

  mat_result_streamer #(.DATA_W(8), .N_ELEM(4), .RELU_EN(0), .CNT_W(2)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_bias(in_bias), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_idx(out_idx0),
    .out_last(out_last0), .frame_cnt(frame_cnt0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor for the ReLU instance.
  always @(negedge clk) begin
    if (!reset && out_valid1 && out_ready) begin
      xfer_cyc.push_back(cyc);
      if (q1.size() == 0) begin
        chk("relu_unexpected_byte", 32'(out_data1), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("relu_data", 32'(out_data1), 32'(e.d));
        chk("relu_idx",  32'(out_idx1),  32'(e.i));
        chk("relu_last", 32'(out_last1), 32'(e.l));
      end
    end
  end

  // Monitor for the pass-through instance.
  always @(negedge clk) begin
    if (!reset && out_valid0 && out_ready) begin
      if (q0.size() == 0) begin
        chk("pass_unexpected_byte", 32'(out_data0), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("pass_data", 32'(out_data0), 32'(e.d));
        chk("pass_idx",  32'(out_idx0),  32'(e.i));
        chk("pass_last", 32'(out_last0), 32'(e.l));
      end
    end
  end

  // Offer a frame, queue its expected bytes, and hold it until accepted.
  task automatic send_frame(input logic [31:0] d, input logic [7:0] b,
                            input logic [31:0] e1, input logic [31:0] e0);
    int  n;
    logic acc;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.i = 2'(i);
      e.l = (i == 3);
      e.d = e1[31-8*i -: 8];
      q1.push_back(e);
      e.d = e0[31-8*i -: 8];
      q0.push_back(e);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_bias  = b;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready1;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 32'(n), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((out_valid1 || q1.size() != 0 || q0.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'(n), 32'd0);
  endtask

  task automatic check_cnt(input string name);
    chk({name, "_cnt16"}, 32'(frame_cnt1), 32'(fc));
    chk({name, "_cnt2"},  32'(frame_cnt0), 32'(fc % 4));
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_bias   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_out_data",  32'(out_data1),  32'd0);
    chk("rst_out_idx",   32'(out_idx1),   32'd0);
    chk("rst_out_last",  32'(out_last1),  32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt1), 32'd0);
    chk("rst_in_ready",  32'(in_ready1),  32'd1);
    @(posedge clk);
    #1;

    // Basic frame
    send_frame(32'h01020304, 8'h00, 32'h01020304, 32'h01020304);
    wait_drain();
    fc = 1;
    check_cnt("basic");

    // Positive saturation, negative values, zero result, plain add
    send_frame(32'h7F80F010, 8'h10, 32'h7F000020, 32'h7F900020);
    wait_drain();
    fc = 2;
    check_cnt("sat_pos");

    // Negative bias: negative saturation and negative results
    send_frame(32'h807F05FF, 8'hF0, 32'h006F0000, 32'h806FF5EF);
    wait_drain();
    fc = 3;
    check_cnt("sat_neg");

    // Backpressure on element 2; the 2-bit counter wraps to 0 here
    send_frame(32'h11223344, 8'h00, 32'h11223344, 32'h11223344);
    n = 0;
    while (!(out_valid1 && out_idx1 == 2'd2) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_reach_idx2", 32'(out_idx1), 32'd2);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid1), 32'd1);
      chk("bp_hold_idx",   32'(out_idx1),   32'd2);
      chk("bp_hold_data",  32'(out_data1),  32'h33);
      chk("bp_in_ready",   32'(in_ready1),  32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain();
    fc = 4;
    check_cnt("bp");

    // Back-to-back frames with no bubble
    xfer_cyc.delete();
    send_frame(32'hA0B0C0D0, 8'h01, 32'h00000000, 32'hA1B1C1D1);
    send_frame(32'h10203040, 8'hFF, 32'h0F1F2F3F, 32'h0F1F2F3F);
    wait_drain();
    fc = 6;
    check_cnt("b2b");
    chk("b2b_xfers", 32'(xfer_cyc.size()), 32'd8);
    if (xfer_cyc.size() == 8) chk("b2b_span", 32'(xfer_cyc[7] - xfer_cyc[0]), 32'd7);

    // Reset mid-frame, with in_valid asserted during the reset cycle
    send_frame(32'h01020304, 8'h00, 32'h01020304, 32'h01020304);
    n = 0;
    while (!(out_valid1 && out_idx1 == 2'd2) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_reach_idx2", 32'(out_idx1), 32'd2);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h55555555;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    q1.delete();
    q0.delete();
    fc = 0;
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid1), 32'd0);
    chk("mid_out_data",  32'(out_data1),  32'd0);
    chk("mid_in_ready",  32'(in_ready1),  32'd1);
    check_cnt("mid");
    @(posedge clk);
    #1;
    send_frame(32'h05060708, 8'h00, 32'h05060708, 32'h05060708);
    wait_drain();
    fc = 1;
    check_cnt("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
